// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM/select encodings and constants for the fetch unit
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} fetch_state_t;
  typedef enum logic [1:0] {PC_SEL_SEQ = 2'b00, PC_SEL_BR = 2'b01, PC_SEL_JALR = 2'b10} pc_sel_t;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC select and word alignment (FETCH_MISALIGN_TRAP_EN exposes raw target)
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [31:0] pc_imm_i,
  input  logic [31:0] alu_jalr_i,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic [31:0] target_o,
`endif
  output logic [31:0] next_pc_o
);
  logic [31:0] target;
  always_comb begin
    target = pc_sel_i == PC_SEL_BR   ? pc_imm_i :
             pc_sel_i == PC_SEL_JALR ? (alu_jalr_i & 32'hFFFF_FFFE) :
                                       pc_i + 32'd4;
    next_pc_o = target & ALIGN_MASK;
  end
`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_o = target;
`endif
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and single-outstanding IMem fetch sequencer feeding decode.
// FETCH_MISALIGN_TRAP_EN adds Misalign_Err/Misalign_Addr and traps on bit-1 targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  PC_Sel,
  input  logic [31:0] PC_Imm,
  input  logic [31:0] ALU_JALR,
  output logic        IMem_Req_Valid,
  input  logic        IMem_Req_Ready,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Rsp_Valid,
  input  logic [31:0] IMem_Rsp_Data,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  output logic [31:0] Inst,
  output logic [31:0] PC_Out,
  output logic [31:0] PC_4,
  output logic        Fetch_Err
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        Misalign_Err,
  output logic [31:0] Misalign_Addr
`endif
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, inst_q, inst_d, cnt_q, cnt_d, next_pc;
  logic         err_q, err_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic         mis_err_q, mis_err_d;
  logic [31:0]  mis_addr_q, mis_addr_d, target;
`endif
  next_pc_sel u_next_pc_sel (
    .pc_i       (pc_q),
    .pc_sel_i   (PC_Sel),
    .pc_imm_i   (PC_Imm),
    .alu_jalr_i (ALU_JALR),
`ifdef FETCH_MISALIGN_TRAP_EN
    .target_o   (target),
`endif
    .next_pc_o  (next_pc)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_err_d  = mis_err_q;
    mis_addr_d = mis_addr_q;
`endif
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = IMem_Req_Ready ? WAIT : REQ;
      WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (IMem_Rsp_Valid) begin
          inst_d  = IMem_Rsp_Data;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (RSP_TIMEOUT != 0 && cnt_q == RSP_TIMEOUT - 1) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      HOLD: if (Inst_Ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (target[1]) begin
          mis_err_d  = 1'b1;
          mis_addr_d = target;
          state_d    = ERR;
        end else begin
          pc_d    = next_pc;
          state_d = REQ;
        end
`else
        pc_d    = next_pc;
        state_d = REQ;
`endif
      end
      ERR: state_d = ERR;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_err_q  <= 1'b0;
      mis_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_err_q  <= mis_err_d;
      mis_addr_q <= mis_addr_d;
`endif
    end
  end
  assign IMem_Req_Valid = state_q == REQ;
  assign IMem_Addr      = pc_q;
  assign Inst_Valid     = state_q == HOLD;
  assign Inst           = inst_q;
  assign PC_Out         = pc_q;
  assign PC_4           = pc_q + 32'd4;
  assign Fetch_Err      = err_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign Misalign_Err   = mis_err_q;
  assign Misalign_Addr  = mis_addr_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and randomized checks of fetch_unit against a next-PC model
module tb_fetch_unit;
  logic        CLK = 1'b0, RST = 1'b1;
  logic [1:0]  PC_Sel = '0;
  logic [31:0] PC_Imm = '0, ALU_JALR = '0, IMem_Rsp_Data = '0;
  logic        IMem_Req_Ready = 1'b0, IMem_Rsp_Valid = 1'b0, Inst_Ready = 1'b0;
  logic        IMem_Req_Valid, Inst_Valid, Fetch_Err;
  logic [31:0] IMem_Addr, Inst, PC_Out, PC_4;
  int total = 0, bad = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .RSP_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .PC_Sel(PC_Sel), .PC_Imm(PC_Imm), .ALU_JALR(ALU_JALR),
    .IMem_Req_Valid(IMem_Req_Valid), .IMem_Req_Ready(IMem_Req_Ready), .IMem_Addr(IMem_Addr),
    .IMem_Rsp_Valid(IMem_Rsp_Valid), .IMem_Rsp_Data(IMem_Rsp_Data),
    .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Inst(Inst), .PC_Out(PC_Out),
    .PC_4(PC_4), .Fetch_Err(Fetch_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] imm, jalr;
    int          rdy, rsp, hold;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  // Next PC from the architectural rules: pick target, then force word alignment.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] sel,
                                             input logic [31:0] imm, input logic [31:0] jalr);
    logic [31:0] t;
    case (sel)
      2'b01:   t = imm;
      2'b10:   t = jalr;
      default: t = pc + 32'd4;
    endcase
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!IMem_Req_Valid && n < 8) begin
      tick();
      n++;
    end
    chk("req_valid", 32'(IMem_Req_Valid), 1);
  endtask

  task automatic serve(input logic [31:0] exp, input int rdy_dly, input int rsp_dly);
    wait_req();
    chk("req_addr", IMem_Addr, exp);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk("req_stall_valid", 32'(IMem_Req_Valid), 1);
      chk("req_stall_addr", IMem_Addr, exp);
    end
    IMem_Req_Ready = 1'b1;
    IMem_Rsp_Valid = 1'b1;
    IMem_Rsp_Data  = 32'hDEAD_BEEF;
    tick();
    IMem_Req_Ready = 1'b0;
    IMem_Rsp_Valid = 1'b0;
    for (int i = 1; i < rsp_dly; i++) tick();
    IMem_Rsp_Valid = 1'b1;
    IMem_Rsp_Data  = mem_word(exp);
    tick();
    IMem_Rsp_Valid = 1'b0;
    chk("inst_valid", 32'(Inst_Valid), 1);
    chk("inst", Inst, mem_word(exp));
    chk("pc_out", PC_Out, exp);
    chk("pc_4", PC_4, exp + 32'd4);
    chk("fetch_err", 32'(Fetch_Err), 0);
  endtask

  task automatic retire(input logic [31:0] cur, input logic [1:0] sel, input logic [31:0] imm,
                        input logic [31:0] jalr, input int hold, output logic [31:0] nxt);
    for (int i = 0; i < hold; i++) begin
      PC_Sel         = 2'($urandom);
      PC_Imm         = $urandom;
      ALU_JALR       = $urandom;
      IMem_Rsp_Valid = 1'($urandom);
      IMem_Rsp_Data  = $urandom;
      tick();
      chk("hold_valid", 32'(Inst_Valid), 1);
      chk("hold_inst", Inst, mem_word(cur));
      chk("hold_pc", PC_Out, cur);
      chk("hold_no_req", 32'(IMem_Req_Valid), 0);
    end
    IMem_Rsp_Valid = 1'b0;
    PC_Sel     = sel;
    PC_Imm     = imm;
    ALU_JALR   = jalr;
    Inst_Ready = 1'b1;
    tick();
    Inst_Ready = 1'b0;
    PC_Sel     = 2'($urandom);
    PC_Imm     = $urandom;
    ALU_JALR   = $urandom;
    chk("retire_drop_valid", 32'(Inst_Valid), 0);
    chk("retire_next_req", 32'(IMem_Req_Valid), 1);
    nxt = model_next(cur, sel, imm, jalr);
  endtask

  initial begin
    vec_t        vt[9];
    logic [31:0] pc, nx;
    vt[0] = '{2'b00, 32'h0,         32'h0,         0, 1, 0, 32'h0000_0004};
    vt[1] = '{2'b00, 32'h0,         32'h0,         3, 1, 4, 32'h0000_0008};
    vt[2] = '{2'b01, 32'h40,        32'h0,         0, 1, 1, 32'h0000_0040};
    vt[3] = '{2'b10, 32'h0,         32'h101,       0, 2, 0, 32'h0000_0100};
    vt[4] = '{2'b11, 32'h999,       32'h555,       1, 3, 0, 32'h0000_0104};
    vt[5] = '{2'b01, 32'h42,        32'h0,         0, 4, 2, 32'h0000_0040};
    vt[6] = '{2'b10, 32'h0,         32'hFFFF_FFFF, 2, 1, 0, 32'hFFFF_FFFC};
    vt[7] = '{2'b00, 32'h0,         32'h0,         0, 2, 1, 32'h0000_0000};
    vt[8] = '{2'b01, 32'h1000_0007, 32'h0,         1, 1, 2, 32'h1000_0004};

    RST = 1'b1;
    tick();
    tick();
    chk("rst_req_valid", 32'(IMem_Req_Valid), 0);
    chk("rst_inst_valid", 32'(Inst_Valid), 0);
    chk("rst_fetch_err", 32'(Fetch_Err), 0);
    chk("rst_pc", PC_Out, 32'h0);
    chk("rst_inst", Inst, 32'h0);
    RST = 1'b0;
    chk("idle_no_req", 32'(IMem_Req_Valid), 0);
    tick();
    chk("first_req", 32'(IMem_Req_Valid), 1);
    pc = 32'h0;
    serve(pc, 0, 1);

    for (int i = 0; i < 9; i++) begin
      retire(pc, vt[i].sel, vt[i].imm, vt[i].jalr, vt[i].hold, nx);
      serve(vt[i].exp, vt[i].rdy, vt[i].rsp);
      pc = vt[i].exp;
    end

    for (int i = 0; i < 60; i++) begin
      retire(pc, 2'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)), nx);
      serve(nx, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
      pc = nx;
    end

    retire(pc, 2'b00, 32'h0, 32'h0, 0, nx);
    wait_req();
    chk("to_addr", IMem_Addr, nx);
    IMem_Req_Ready = 1'b1;
    tick();
    IMem_Req_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_not_yet", 32'(Fetch_Err), 0);
    end
    tick();
    chk("to_err", 32'(Fetch_Err), 1);
    chk("to_req_drop", 32'(IMem_Req_Valid), 0);
    chk("to_inst_drop", 32'(Inst_Valid), 0);
    IMem_Rsp_Valid = 1'b1;
    IMem_Req_Ready = 1'b1;
    Inst_Ready     = 1'b1;
    tick();
    IMem_Rsp_Valid = 1'b0;
    IMem_Req_Ready = 1'b0;
    Inst_Ready     = 1'b0;
    chk("err_sticky", 32'(Fetch_Err), 1);
    chk("err_no_inst", 32'(Inst_Valid), 0);
    chk("err_no_req", 32'(IMem_Req_Valid), 0);

    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rec_err_clear", 32'(Fetch_Err), 0);
    chk("rec_pc", PC_Out, 32'h0);
    tick();
    chk("rec_req", 32'(IMem_Req_Valid), 1);
    pc = 32'h0;
    serve(pc, 0, 1);

    retire(pc, 2'b00, 32'h0, 32'h0, 0, nx);
    wait_req();
    IMem_Req_Ready = 1'b1;
    tick();
    IMem_Req_Ready = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_no_req", 32'(IMem_Req_Valid), 0);
    chk("mid_rst_pc", PC_Out, 32'h0);
    tick();
    IMem_Rsp_Valid = 1'b1;
    IMem_Rsp_Data  = 32'hBAAD_F00D;
    tick();
    IMem_Rsp_Valid = 1'b0;
    chk("stale_still_req", 32'(IMem_Req_Valid), 1);
    chk("stale_no_inst", 32'(Inst_Valid), 0);
    chk("stale_addr", IMem_Addr, 32'h0);
    serve(32'h0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
